sha2_round_engine: RTL and testbench

Iterative SHA-2 compression engine: accepts an 8-word chaining state, runs all rounds of the SHA-256 or SHA-512 compression function one round per cycle, optionally adds the input state back (feed-forward), and returns the result. It sits between the message-schedule block, which supplies K_t/W_t indexed by `t_o`, and the hash controller, which owns padding and chaining. It supersedes the single-round cell with word-width parametrisation, an internal round counter, a flush input and a proper two-sided valid/ready handshake.

---
 rtl/sha2_round_engine.sv | 133 +++++++++++++
 tb/tb_sha2_round_engine.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_round_engine.sv
// Iterative SHA-256 / SHA-512 compression engine: one round per clock, an
// optional feed-forward of the chaining state, and valid/ready on both sides.
module sha2_round_engine #(
    parameter int WORD    = 32,
    parameter bit FEEDFWD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [8*WORD-1:0] state_i,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [6:0]        t_o,
    input  logic [WORD-1:0]   k_i,
    input  logic [WORD-1:0]   w_i,
    output logic              busy,
    output logic [8*WORD-1:0] state_o,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int         ROUNDS = (WORD == 64) ? 80 : 64;
    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);
    localparam int S0_A = (WORD == 64) ? 28 : 2;
    localparam int S0_B = (WORD == 64) ? 34 : 13;
    localparam int S0_C = (WORD == 64) ? 39 : 22;
    localparam int S1_A = (WORD == 64) ? 14 : 6;
    localparam int S1_B = (WORD == 64) ? 18 : 11;
    localparam int S1_C = (WORD == 64) ? 41 : 25;

    generate
        if (WORD != 32 && WORD != 64) begin : g_bad_word
            $error("sha2_round_engine: WORD must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [6:0]      t_q;
    logic [WORD-1:0] a, b, c, d, e, f, g, h;
    logic [8*WORD-1:0] h_save;
    logic [WORD-1:0] sig0, sig1, ch, maj, t1, t2;
    logic [8*WORD-1:0] vars_next, digest;

    function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int n);
        return (x >> n) | (x << (WORD - n));
    endfunction

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no latch is inferred; clocked blocks use '<=' only.
    always_comb begin
        sig0 = rotr(a, S0_A) ^ rotr(a, S0_B) ^ rotr(a, S0_C);
        sig1 = rotr(e, S1_A) ^ rotr(e, S1_B) ^ rotr(e, S1_C);
        ch   = (e & f) ^ (~e & g);
        maj  = (a & b) ^ (a & c) ^ (b & c);
        t1   = h + sig1 + ch + k_i + w_i;
        t2   = sig0 + maj;
        vars_next = {t1 + t2, a, b, c, d + t1, e, f, g};
        digest    = vars_next;
        if (FEEDFWD) begin
            for (int i = 0; i < 8; i++) begin
                digest[i*WORD +: WORD] = vars_next[i*WORD +: WORD] + h_save[i*WORD +: WORD];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= S_IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        if (flush) begin
            fsm_d = S_IDLE;
        end else begin
            case (fsm_q)
                S_IDLE:  if (in_valid)       fsm_d = S_RUN;
                S_RUN:   if (t_q == LAST_T)  fsm_d = S_DONE;
                S_DONE:  if (out_ready)      fsm_d = S_IDLE;
                default:                     fsm_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (fsm_q == S_IDLE);
        busy     = (fsm_q == S_RUN);
    end

    assign t_o = t_q;

    // Round counter and result register; flush clears them ahead of any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q       <= '0;
            out_valid <= 1'b0;
            state_o   <= '0;
        end else if (flush) begin
            t_q       <= '0;
            out_valid <= 1'b0;
            state_o   <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: if (in_valid) t_q <= '0;
                S_RUN: begin
                    if (t_q == LAST_T) begin
                        t_q       <= '0;
                        state_o   <= digest;
                        out_valid <= 1'b1;
                    end else begin
                        t_q <= t_q + 7'd1;
                    end
                end
                S_DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // NOTE: working variables and the saved chaining state are always written
    // before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fsm_q == S_IDLE && in_valid && !flush) begin
            {a, b, c, d, e, f, g, h} <= state_i;
            h_save                   <= state_i;
        end else if (fsm_q == S_RUN) begin
            {a, b, c, d, e, f, g, h} <= vars_next;
        end
    end

endmodule

// File: tb/tb_sha2_round_engine.sv
// Self-checking bench for sha2_round_engine: SHA-256 with and without
// feed-forward plus SHA-512, against a behavioural compression model.
module tb_sha2_round_engine;

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [255:0] ABC256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    // SHA-256 pair (feed-forward on and off) share every input
    logic [255:0] st32_i = '0;
    logic         iv32 = 1'b0, or32 = 1'b0;
    logic [31:0]  k_a, w_a, k_b, w_b;
    logic         rdy_a, busy_a, ov_a, rdy_b, busy_b, ov_b;
    logic [6:0]   t_a, t_b;
    logic [255:0] so_a, so_b;

    logic [511:0] st64_i = '0;
    logic         iv64 = 1'b0, or64 = 1'b0;
    logic [63:0]  k_c, w_c;
    logic         rdy_c, busy_c, ov_c;
    logic [6:0]   t_c;
    logic [511:0] so_c;

    logic [63:0] wt32 [80];
    logic [63:0] wt64 [80];

    assign k_a = K512[t_a][63:32];
    assign w_a = wt32[t_a][31:0];
    assign k_b = K512[t_b][63:32];
    assign w_b = wt32[t_b][31:0];
    assign k_c = K512[t_c];
    assign w_c = wt64[t_c];

    sha2_round_engine #(.WORD(32), .FEEDFWD(1'b1)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .state_i(st32_i), .in_valid(iv32),
        .in_ready(rdy_a), .t_o(t_a), .k_i(k_a), .w_i(w_a), .busy(busy_a),
        .state_o(so_a), .out_valid(ov_a), .out_ready(or32));

    sha2_round_engine #(.WORD(32), .FEEDFWD(1'b0)) u32n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .state_i(st32_i), .in_valid(iv32),
        .in_ready(rdy_b), .t_o(t_b), .k_i(k_b), .w_i(w_b), .busy(busy_b),
        .state_o(so_b), .out_valid(ov_b), .out_ready(or32));

    sha2_round_engine #(.WORD(64), .FEEDFWD(1'b1)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .state_i(st64_i), .in_valid(iv64),
        .in_ready(rdy_c), .t_o(t_c), .k_i(k_c), .w_i(w_c), .busy(busy_c),
        .state_o(so_c), .out_valid(ov_c), .out_ready(or64));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit wide);
        logic [31:0] lo;
        if (wide) return (x >> n) | (x << (64 - n));
        lo = x[31:0];
        lo = (lo >> n) | (lo << (32 - n));
        return {32'h0, lo};
    endfunction

    function automatic logic [63:0] big_s0(input logic [63:0] x, input bit wide);
        if (wide) return rotr(x, 28, 1) ^ rotr(x, 34, 1) ^ rotr(x, 39, 1);
        return rotr(x, 2, 0) ^ rotr(x, 13, 0) ^ rotr(x, 22, 0);
    endfunction

    function automatic logic [63:0] big_s1(input logic [63:0] x, input bit wide);
        if (wide) return rotr(x, 14, 1) ^ rotr(x, 18, 1) ^ rotr(x, 41, 1);
        return rotr(x, 6, 0) ^ rotr(x, 11, 0) ^ rotr(x, 25, 0);
    endfunction

    function automatic logic [63:0] sml_s0(input logic [63:0] x, input bit wide);
        if (wide) return rotr(x, 1, 1) ^ rotr(x, 8, 1) ^ (x >> 7);
        return rotr(x, 7, 0) ^ rotr(x, 18, 0) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] sml_s1(input logic [63:0] x, input bit wide);
        if (wide) return rotr(x, 19, 1) ^ rotr(x, 61, 1) ^ (x >> 6);
        return rotr(x, 17, 0) ^ rotr(x, 19, 0) ^ (x >> 10);
    endfunction

    function automatic logic [511:0] ref_compress(input logic [511:0] st, input bit wide, input bit ff);
        logic [63:0]  v [8];
        logic [63:0]  h0 [8];
        logic [63:0]  mask, t1, t2, kv, wv;
        logic [511:0] res;
        int           n, ws;
        ws   = wide ? 64 : 32;
        n    = wide ? 80 : 64;
        mask = wide ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        for (int i = 0; i < 8; i++) begin
            h0[i] = (st >> ((7 - i) * ws)) & {448'h0, mask};
            v[i]  = h0[i];
        end
        for (int r = 0; r < n; r++) begin
            kv = wide ? K512[r] : {32'h0, K512[r][63:32]};
            wv = wide ? wt64[r] : wt32[r];
            t1 = (v[7] + big_s1(v[4], wide) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kv + wv) & mask;
            t2 = (big_s0(v[0], wide) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]))) & mask;
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = (v[4] + t1) & mask;
            v[0] = (t1 + t2) & mask;
        end
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res = (res << ws) | {448'h0, (ff ? (v[i] + h0[i]) : v[i]) & mask};
        end
        return res;
    endfunction

    // Schedule for the single padded "abc" block
    task automatic fill_abc(input bit wide);
        logic [63:0] w [80];
        for (int t = 0; t < 80; t++) w[t] = '0;
        w[0]  = wide ? 64'h6162638000000000 : 64'h61626380;
        w[15] = 64'h18;
        for (int t = 16; t < 80; t++) begin
            w[t] = sml_s1(w[t-2], wide) + w[t-7] + sml_s0(w[t-15], wide) + w[t-16];
            if (!wide) w[t] = w[t] & 64'hffff_ffff;
        end
        for (int t = 0; t < 80; t++) begin
            if (wide) wt64[t] = w[t];
            else      wt32[t] = w[t];
        end
    endtask

    task automatic fill_random(input bit wide);
        for (int t = 0; t < 80; t++) begin
            if (wide) wt64[t] = {$urandom, $urandom};
            else      wt32[t] = {32'h0, $urandom};
        end
    endtask

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic start32(input logic [255:0] st);
        st32_i = st;
        iv32   = 1'b1;
        check("in_ready32_idle", {510'h0, rdy_a, rdy_b}, 512'h3);
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0;
        check("t_o32_after_accept", {t_a, t_b}, 512'h0);
        check("busy32_after_accept", {busy_a, busy_b, rdy_a}, 512'h6);
    endtask

    task automatic start64(input logic [511:0] st);
        st64_i = st;
        iv64   = 1'b1;
        check("in_ready64_idle", rdy_c, 1);
        @(posedge clk);
        @(negedge clk);
        iv64 = 1'b0;
        check("t_o64_after_accept", t_c, 0);
    endtask

    task automatic wait32(output int lat);
        lat = 0;
        while (!ov_a && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic wait64(output int lat);
        lat = 0;
        while (!ov_c && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic hs32();
        or32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or32 = 1'b0;
        check("hs32_back_to_idle", {ov_a, ov_b, rdy_a, rdy_b}, 512'h3);
    endtask

    task automatic hs64();
        or64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or64 = 1'b0;
        check("hs64_back_to_idle", {ov_c, rdy_c}, 512'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, cnt;
        logic [255:0] st1, st2, hold;
        logic [511:0] st64, exp64;

        for (int t = 0; t < 80; t++) begin
            wt32[t] = '0;
            wt64[t] = '0;
        end

        // Reset state
        #3;
        check("reset32", {rdy_a, busy_a, t_a, ov_a, so_a}, {1'b1, 1'b0, 7'd0, 1'b0, 256'h0});
        check("reset32n", {rdy_b, busy_b, t_b, ov_b, so_b}, {1'b1, 1'b0, 7'd0, 1'b0, 256'h0});
        check("reset64", {rdy_c, busy_c, t_c, ov_c, so_c}, {1'b1, 1'b0, 7'd0, 1'b0, 512'h0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // SHA-256 "abc", feed-forward on and off
        fill_abc(1'b0);
        start32(IV256);
        wait32(lat);
        check("abc256_latency", lat, 64);
        check("abc256_digest", so_a, ABC256);
        check("abc256_nofeed_a_word", so_b[255:224], 32'h506e3058);
        check("abc256_nofeed_model", so_b, ref_compress({256'h0, IV256}, 1'b0, 1'b0));
        check("abc256_t_o_wrapped", {t_a, ov_b}, {7'd0, 1'b1});
        hs32();

        // SHA-512 "abc"
        fill_abc(1'b1);
        start64(IV512);
        wait64(lat);
        check("abc512_latency", lat, 80);
        check("abc512_a_word", so_c[511:448], 64'hddaf35a193617aba);
        check("abc512_h_word_low", so_c[31:0], 32'ha54ca49f);
        check("abc512_model", so_c, ref_compress(IV512, 1'b1, 1'b1));
        hs64();

        // Random blocks against the model
        for (int n = 0; n < 3; n++) begin
            fill_random(1'b0);
            st1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            start32(st1);
            st32_i = ~st1;
            wait32(lat);
            check("rand256_latency", lat, 64);
            check("rand256_digest", so_a, ref_compress({256'h0, st1}, 1'b0, 1'b1));
            check("rand256_nofeed", so_b, ref_compress({256'h0, st1}, 1'b0, 1'b0));
            hs32();
        end
        for (int n = 0; n < 2; n++) begin
            fill_random(1'b1);
            st64 = '0;
            for (int i = 0; i < 16; i++) st64 = (st64 << 32) | {480'h0, $urandom};
            start64(st64);
            exp64 = ref_compress(st64, 1'b1, 1'b1);
            wait64(lat);
            check("rand512_latency", lat, 80);
            check("rand512_digest", so_c, exp64);
            hs64();
        end

        // Backpressure: 20 stalled cycles with a second block waiting
        fill_random(1'b0);
        st1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        st2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start32(st1);
        wait32(lat);
        check("bp_first_digest", so_a, ref_compress({256'h0, st1}, 1'b0, 1'b1));
        hold   = so_a;
        st32_i = st2;
        iv32   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_stall_hold", {ov_a, rdy_a, busy_a, so_a}, {1'b1, 1'b0, 1'b0, hold});
        end
        or32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or32 = 1'b0;
        check("bp_ready_after_hs", {rdy_a, ov_a}, 2'b10);
        @(posedge clk);
        @(negedge clk);
        iv32   = 1'b0;
        st32_i = st1;
        check("bp_second_accepted", {busy_a, t_a}, {1'b1, 7'd0});
        wait32(lat);
        check("bp_second_latency", lat, 64);
        check("bp_second_digest", so_a, ref_compress({256'h0, st2}, 1'b0, 1'b1));
        hs32();

        // Flush at t_o = 30, then a clean "abc"
        fill_abc(1'b0);
        start32(IV256);
        cnt = 0;
        while (t_a != 7'd30 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("flush_reached_t30", t_a, 30);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {rdy_a, busy_a, t_a, ov_a, so_a}, {1'b1, 1'b0, 7'd0, 1'b0, 256'h0});
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ov_a || ov_b) cnt++;
        end
        check("flush_no_out_valid", cnt, 0);
        start32(IV256);
        wait32(lat);
        check("flush_then_abc_latency", lat, 64);
        check("flush_then_abc_digest", so_a, ABC256);
        hs32();

        // Asynchronous reset at t_o = 10, between clock edges
        start32(IV256);
        cnt = 0;
        while (t_a != 7'd10 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("areset_reached_t10", t_a, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_immediate", {rdy_a, busy_a, t_a, ov_a, so_a}, {1'b1, 1'b0, 7'd0, 1'b0, 256'h0});
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ov_a || busy_a) cnt++;
        end
        check("areset_no_output", cnt, 0);
        start32(IV256);
        wait32(lat);
        check("areset_then_abc_digest", so_a, ABC256);
        hs32();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
